// File: rtl/pxl_stream_src.sv
// pxl_stream_src: streams a W x H frame out of a synchronous-read image RAM
// as one pixel per clock in raster order, with sof/eol/eof markers aligned
// to each pixel. Reads are issued in stage 0, data returns in stage 1 and is
// registered onto the output in stage 2.
module pxl_stream_src #(
    parameter int W      = 220,
    parameter int H      = 220,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] pxl_out,
    output logic              valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
    localparam logic [15:0]      GAP_LAST = 16'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic              flush_cnt_q, flush_cnt_d;

    logic              issue;
    logic              last_col;
    logic              last_row;
    logic              first_pix;

    // Stage-1 sideband (travels alongside the outstanding RAM read)
    logic              rd1_q, rd1_d;
    logic              sof1_q, sof1_d;
    logic              eol1_q, eol1_d;
    logic              eof1_q, eof1_d;

    // Stage-2 output register
    logic [DATA_W-1:0] pxl_q, pxl_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;

    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);
    assign first_pix = (col_q == '0) && (row_q == '0);

    // Next-state logic: read issue, running address and col/row counters
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        col_d       = col_q;
        row_d       = row_q;
        gap_cnt_d   = gap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            addr_d      = '0;
                            row_d       = '0;
                            flush_cnt_d = 1'b0;
                            state_d     = ST_FLUSH;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            row_d  = row_q + ROW_W'(1);
                            if (GAP > 0) begin
                                gap_cnt_d = '0;
                                state_d   = ST_GAP;
                            end
                        end
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, address and position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            gap_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_cnt_q   <= gap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Pipeline next values: flags computed at issue, delayed to meet their pixel
    always_comb begin
        rd1_d   = issue;
        sof1_d  = issue && first_pix;
        eol1_d  = issue && last_col;
        eof1_d  = issue && last_col && last_row;
        valid_d = rd1_q;
        sof_d   = sof1_q;
        eol_d   = eol1_q;
        eof_d   = eof1_q;
        pxl_d   = rd1_q ? mem_data : pxl_q;
    end

    // Pipeline registers; reset drops any reads still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_q   <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            pxl_q   <= '0;
        end else begin
            rd1_q   <= rd1_d;
            sof1_q  <= sof1_d;
            eol1_q  <= eol1_d;
            eof1_q  <= eof1_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            pxl_q   <= pxl_d;
        end
    end

    assign mem_rd   = issue;
    assign mem_addr = addr_q;
    assign pxl_out  = pxl_q;
    assign valid    = valid_q;
    assign sof      = sof_q;
    assign eol      = eol_q;
    assign eof      = eof_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_GAP) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_pxl_stream_src.sv
// tb_pxl_stream_src: scoreboard bench for pxl_stream_src on a small 4x3 frame
// with a 2-cycle line gap. Expected pixels, flags and read addresses are
// queued when a frame is started and compared as the DUT produces them.
module tb_pxl_stream_src;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int GAP    = 2;
    localparam int NPIX   = W * H;
    localparam int DONE_CYC = NPIX + (H - 1) * GAP + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              hold;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data = '0;
    logic [DATA_W-1:0] pxl_out;
    logic              valid;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              busy;
    logic              done;

    logic [30:0] outVec;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;
    int startCyc = 1000000;
    int rel;
    int firstRd, firstValid, nValid, nDone, nBusy, doneRel;
    logic [63:0] vlog;
    bit monEn = 1'b0;

    logic [10:0] expPix[$];
    logic [15:0] expAddr[$];

    always #5 clk = ~clk;

    pxl_stream_src #(
        .W(W), .H(H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .hold(hold),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .pxl_out(pxl_out),
        .valid(valid),
        .sof(sof),
        .eol(eol),
        .eof(eof),
        .busy(busy),
        .done(done)
    );

    assign outVec = {mem_rd, mem_addr, pxl_out, valid, sof, eol, eof, busy, done};

    // Image content: a simple scrambled ramp so wrong addresses show up
    function automatic logic [7:0] ramVal(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    // Synchronous-read RAM model: data appears the cycle after the read
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ramVal(int'(mem_addr));
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: compare every read address and every delivered pixel
    always @(negedge clk) begin
        cyc++;
        if (monEn) begin
            rel = cyc - startCyc;
            if (mem_rd) begin
                if (firstRd == 0) firstRd = rel;
                if (expAddr.size() == 0) checkOutput("unexpected mem_rd", 1, 0);
                else checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr.pop_front()));
            end
            if (valid) begin
                if (firstValid == 0) firstValid = rel;
                nValid++;
                if (expPix.size() == 0) checkOutput("unexpected valid", 1, 0);
                else checkOutput("pixel+flags", 32'({pxl_out, sof, eol, eof}), 32'(expPix.pop_front()));
            end else begin
                checkOutput("flags while idle", 32'({sof, eol, eof}), 0);
            end
            if (rel >= 0 && rel < 64) vlog[rel] = valid;
            if (busy) nBusy++;
            if (done) begin
                nDone++;
                doneRel = rel;
            end
        end
    end

    // Runs one frame: start at edge 0, then per-cycle hold/start/reset masks
    task automatic applyStimulus(input logic [63:0] holdMask, input logic [63:0] startMask,
                                 input int resetAt, input bit expectFrame);
        @(posedge clk);
        #1;
        start = 1'b1;
        hold  = 1'b0;
        reset = 1'b0;
        if (expectFrame) begin
            for (int k = 0; k < NPIX; k++) begin
                expAddr.push_back(16'(k));
                expPix.push_back({ramVal(k), (k == 0), ((k % W) == W - 1), (k == NPIX - 1)});
            end
        end
        firstRd    = 0;
        firstValid = 0;
        nValid     = 0;
        nDone      = 0;
        nBusy      = 0;
        doneRel    = -1;
        vlog       = '0;
        startCyc   = 1000000;
        @(posedge clk);
        startCyc = cyc;
        for (int c = 1; c < 40; c++) begin
            #1;
            start = startMask[c];
            hold  = holdMask[c];
            reset = (c == resetAt);
            if (resetAt > 0 && c == resetAt + 1) begin
                @(negedge clk);
                checkOutput("outputs after mid-frame reset", 32'(outVec), 0);
            end
            @(posedge clk);
            if (c == resetAt) begin
                expPix.delete();
                expAddr.delete();
            end
        end
        #1;
        start = 1'b0;
        hold  = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] mask;
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset state", 32'(outVec), 0);
        monEn = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] frame 1: plain frame with line gaps");
        applyStimulus('0, '0, 0, 1'b1);
        checkOutput("f1 first mem_rd cycle", firstRd, 1);
        checkOutput("f1 first valid cycle", firstValid, 3);
        checkOutput("f1 valid pattern", 32'(vlog[18:3]), 32'(16'b1111001111001111));
        checkOutput("f1 no valid on done", 32'(vlog[19]), 0);
        checkOutput("f1 done cycle", doneRel, DONE_CYC);
        checkOutput("f1 done count", nDone, 1);
        checkOutput("f1 pixel count", nValid, NPIX);
        checkOutput("f1 busy cycles", nBusy, DONE_CYC - 1);
        checkOutput("f1 leftover pixels", expPix.size(), 0);

        $display("[TB] frame 2: hold on issue cycles 2-3 and during gap 7-8");
        mask = '0;
        mask[2] = 1'b1;
        mask[3] = 1'b1;
        mask[7] = 1'b1;
        mask[8] = 1'b1;
        applyStimulus(mask, '0, 0, 1'b1);
        checkOutput("f2 first valid cycle", firstValid, 3);
        checkOutput("f2 valid gap", 32'(vlog[5:3]), 32'(3'b001));
        checkOutput("f2 done cycle", doneRel, DONE_CYC + 2);
        checkOutput("f2 done count", nDone, 1);
        checkOutput("f2 pixel count", nValid, NPIX);
        checkOutput("f2 busy cycles", nBusy, DONE_CYC + 1);
        checkOutput("f2 leftover pixels", expPix.size(), 0);

        $display("[TB] frame 3: start pulsed mid-frame and in the done cycle");
        mask = '0;
        mask[8] = 1'b1;
        mask[DONE_CYC] = 1'b1;
        applyStimulus('0, mask, 0, 1'b1);
        checkOutput("f3 done cycle", doneRel, DONE_CYC);
        checkOutput("f3 done count", nDone, 1);
        checkOutput("f3 pixel count", nValid, NPIX);
        checkOutput("f3 busy cycles", nBusy, DONE_CYC - 1);
        checkOutput("f3 idle afterwards", 32'(busy), 0);

        $display("[TB] frame 4: reset asserted in cycle 5");
        applyStimulus('0, '0, 5, 1'b1);
        checkOutput("f4 no done after reset", nDone, 0);
        checkOutput("f4 idle afterwards", 32'(busy), 0);

        $display("[TB] frame 5: full frame after reset");
        applyStimulus('0, '0, 0, 1'b1);
        checkOutput("f5 first valid cycle", firstValid, 3);
        checkOutput("f5 done cycle", doneRel, DONE_CYC);
        checkOutput("f5 done count", nDone, 1);
        checkOutput("f5 pixel count", nValid, NPIX);
        checkOutput("f5 leftover pixels", expPix.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

endmodule
